// File: rtl/dbg_snapshot_reader.sv
// Debug snapshot bank: freezes NUM_CH channels in one cycle, gives registered
// random-access readback and streams the frozen bank as a framed byte stream.
module dbg_snapshot_reader #(
  parameter int NUM_CH    = 24,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 7,
  parameter int HEADER_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_channels,
  input  logic                     in_capture,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     in_dump,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     in_ready,
  output logic                     out_busy,
  output logic                     out_done
);

  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [BW-1:0] LAST_B  = BW'(NB - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic [7:0]    NCH8    = 8'(NUM_CH);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE} state_e;

  state_e                           state_q, state_d;
  logic [CW-1:0]                    ch_q, ch_d;
  logic [BW-1:0]                    byte_q, byte_d;
  logic [NUM_CH-1:0][DATA_W-1:0]    snap_q;
  logic [DATA_W-1:0]                rd_d, cur_word;
  logic [7:0]                       data_byte;
  logic                             xfer, cap_en;

  // Capture is only honoured in IDLE so a dump always streams a coherent bank.
  assign cap_en    = in_capture && (state_q == IDLE);
  assign out_valid = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
  assign out_busy  = (state_q != IDLE);
  assign out_done  = (state_q == DONE);
  assign xfer      = out_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      byte_q   <= '0;
      snap_q   <= '0;
      out_data <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      byte_q   <= byte_d;
      out_data <= rd_d;
      if (cap_en) snap_q <= in_channels;
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (in_sel == SEL_W'(i)) rd_d = snap_q[i];
  end

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_q == CW'(i)) cur_word = snap_q[i];
    data_byte = '0;
    for (int b = 0; b < NB; b++)
      if (byte_q == BW'(b)) data_byte = cur_word[(NB-1-b)*8 +: 8];
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    byte_d   = byte_q;
    out_byte = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (in_dump) begin
          state_d = (HEADER_EN != 0) ? HDR0 : DATA;
          ch_d    = '0;
          byte_d  = '0;
        end
      end
      HDR0: begin
        out_byte = 8'hA5;
        if (xfer) state_d = HDR1;
      end
      HDR1: begin
        out_byte = NCH8;
        if (xfer) begin
          state_d = DATA;
          ch_d    = '0;
          byte_d  = '0;
        end
      end
      DATA: begin
        out_byte = data_byte;
        if (xfer) begin
          if (byte_q == LAST_B) begin
            byte_d = '0;
            if (ch_q == LAST_CH) state_d = DONE;
            else                 ch_d    = ch_q + CW'(1);
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbg_snapshot_reader.sv
// Randomised bench for dbg_snapshot_reader against a queue-based byte-stream model.
module tb_dbg_snapshot_reader;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int SW  = 3;

  logic              clk = 0;
  logic              rst = 1;
  logic [NCH-1:0][DW-1:0] live;
  logic              in_capture = 0, in_dump = 0, in_ready = 0;
  logic [SW-1:0]     in_sel = '0;
  logic [DW-1:0]     out_data;
  logic [7:0]        out_byte;
  logic              out_valid, out_busy, out_done;

  logic [DW-1:0]     msnap [NCH];
  int                n_cmp = 0, n_bad = 0;

  dbg_snapshot_reader #(.NUM_CH(NCH), .DATA_W(DW), .SEL_W(SW), .HEADER_EN(1)) dut (
    .clk(clk), .rst(rst), .in_channels(live), .in_capture(in_capture),
    .in_sel(in_sel), .out_data(out_data), .in_dump(in_dump), .out_byte(out_byte),
    .out_valid(out_valid), .in_ready(in_ready), .out_busy(out_busy), .out_done(out_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_dump(input int mode, input bit poke, input bit with_cap);
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] prev_byte = 8'h00;
    bit prev_stall = 0, r;
    int cyc = 0;
    if (with_cap) begin
      for (int c = 0; c < NCH; c++) begin
        live[c]  = $urandom;
        msnap[c] = live[c];
      end
      in_capture = 1;
    end
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(NCH));
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < DW/8; b++)
        exp_q.push_back(8'((msnap[c] >> (8*(DW/8-1-b))) & 32'hFF));
    in_dump = 1;
    tick();
    in_dump = 0; in_capture = 0;
    chk("start_valid", 32'(out_valid), 1);
    chk("start_busy", 32'(out_busy), 1);
    while (got_q.size() < exp_q.size() && cyc < 500) begin
      if (prev_stall) begin
        chk("stall_byte", 32'(out_byte), 32'(prev_byte));
        chk("stall_valid", 32'(out_valid), 1);
      end
      if (mode == 0) chk("valid_run", 32'(out_valid), 1);
      chk("done_early", 32'(out_done), 0);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      in_ready = r;
      if (poke) begin
        in_capture = 1'($urandom_range(0, 1));
        in_dump    = 1'($urandom_range(0, 1));
        for (int c = 0; c < NCH; c++) live[c] = $urandom;
      end
      if (out_valid && r) got_q.push_back(out_byte);
      prev_stall = out_valid && !r;
      prev_byte  = out_byte;
      tick();
      cyc++;
    end
    in_capture = 0; in_dump = 0; in_ready = 0;
    if (cyc >= 500) chk("dump_timeout", 32'(cyc), 0);
    if (mode == 0) chk("dump_cycles", 32'(cyc), 32'(exp_q.size()));
    chk("done_pulse", 32'(out_done), 1);
    chk("done_valid", 32'(out_valid), 0);
    chk("done_busy", 32'(out_busy), 1);
    chk("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    tick();
    chk("done_clear", 32'(out_done), 0);
    chk("idle_busy", 32'(out_busy), 0);
  endtask

  task automatic read_sel(input int s);
    in_sel = SW'(s);
    tick();
    chk($sformatf("sel%0d", s), out_data, (s < NCH) ? msnap[s] : 32'h0);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      live[c]  = 32'h1111_1111 * (c + 1);
      msnap[c] = '0;
    end
    // reset
    repeat (3) tick();
    chk("rst_data", out_data, 0);
    chk("rst_byte", 32'(out_byte), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(out_busy), 0);
    chk("rst_done", 32'(out_done), 0);
    // capture and sweep readback
    rst = 0; in_capture = 1;
    tick();
    in_capture = 0;
    for (int c = 0; c < NCH; c++) msnap[c] = live[c];
    for (int s = 0; s < 8; s++) read_sel(s);
    // freeze
    for (int c = 0; c < NCH; c++) live[c] = 32'hDEAD_BEEF;
    in_sel = 2;
    tick(); tick();
    chk("freeze", out_data, 32'h3333_3333);
    // full dump, backpressure, ignored strobes
    run_dump(0, 0, 0);
    run_dump(1, 0, 0);
    in_sel = 0;
    run_dump(2, 1, 0);
    tick();
    chk("after_poke_sel0", out_data, 32'h1111_1111);
    // capture and dump on the same edge, random data and ready
    for (int k = 0; k < 4; k++) run_dump(2, k[0], 1);
    for (int k = 0; k < 16; k++) read_sel($urandom_range(0, 7));
    // reset mid-dump after 7 accepted bytes
    in_dump = 1;
    tick();
    in_dump = 0; in_ready = 1;
    repeat (7) tick();
    chk("mid_busy", 32'(out_busy), 1);
    rst = 1; in_ready = 0;
    tick();
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(out_busy), 0);
    chk("abort_done", 32'(out_done), 0);
    rst = 0;
    for (int c = 0; c < NCH; c++) msnap[c] = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_done", 32'(out_done), 0);
    end
    read_sel(0);
    run_dump(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
